// File: rtl/mips_mem_pkg.sv
// Shared store-path types: size codes, buffered entry layout and alignment rule.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Entry address field is fixed; instantiating modules keep ADDR_W <= this.
    localparam int ENTRY_ADDR_W = 32;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [31:0]             wdata;
        logic [3:0]              be;
        logic                    lossy;
    } entry_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_narrower_if.sv
// Store request channel plus memory drain channel of the store buffer.
interface store_narrower_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_data;
    logic [1:0]        in_size;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_lossy;
    logic              misalign_err;

    modport slave (
        input  in_valid, in_addr, in_data, in_size, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_lossy, misalign_err
    );

    modport master (
        output in_valid, in_addr, in_data, in_size, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_lossy, misalign_err
    );
endinterface

// File: rtl/store_lane_align.sv
// Combinational narrowing of store data onto little-endian byte lanes,
// byte-enable generation and detection of values that do not survive sign extension.
module store_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        lossy
);

    // Replication puts the narrowed value on every lane; byte enables pick the real one.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata[8*gi +: 8] = (size == SZ_WORD) ? data[8*gi +: 8] :
                                  (size == SZ_HALF) ? data[8*(gi%2) +: 8] :
                                                      data[7:0];
    end

    always_comb begin
        be    = 4'b0000;
        lossy = 1'b0;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                lossy = !((&data[31:7]) || !(|data[31:7]));
            end
            SZ_HALF: begin
                be    = 4'b0011 << addr_lo;
                lossy = !((&data[31:15]) || !(|data[31:15]));
            end
            SZ_WORD: begin
                be    = 4'b1111;
                lossy = 1'b0;
            end
            default: begin
                be    = 4'b0000;
                lossy = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_narrower.sv
// Store narrowing front end feeding a small FIFO that drains to data memory
// over valid/ready; misaligned or reserved-size requests are consumed and flagged.
module store_narrower
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    store_narrower_if.slave          bus,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wptr_reg, rptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             err_reg;

    entry_t buf_mem [DEPTH];
    entry_t new_entry;
    entry_t head;

    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic        al_lossy;
    logic        full, misaligned, accept, push, pop, mem_valid_int;

    store_lane_align u_align (
        .addr_lo (bus.in_addr[1:0]),
        .size    (bus.in_size),
        .data    (bus.in_data),
        .wdata   (al_wdata),
        .be      (al_be),
        .lossy   (al_lossy)
    );

    assign misaligned    = is_misaligned(bus.in_size, bus.in_addr[1:0]);
    assign full          = (count_reg == (PTR_W+1)'(DEPTH));
    assign mem_valid_int = (count_reg != '0);
    assign accept        = bus.in_valid && !full;
    // Flush squashes both ends; a full buffer never takes a push even while popping.
    assign push          = accept && !misaligned && !flush;
    assign pop           = mem_valid_int && bus.mem_ready && !flush;

    always_comb begin
        new_entry       = '0;
        new_entry.addr  = ENTRY_ADDR_W'({bus.in_addr[ADDR_W-1:2], 2'b00});
        new_entry.wdata = al_wdata;
        new_entry.be    = al_be;
        new_entry.lossy = al_lossy;
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else if (flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (push) wptr_reg <= wptr_reg + 1'b1;
            if (pop)  rptr_reg <= rptr_reg + 1'b1;
            count_reg <= count_next;
            err_reg   <= accept && misaligned;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) buf_mem[wptr_reg] <= new_entry;
    end

    assign head = buf_mem[rptr_reg];

    assign bus.in_ready     = !full;
    assign bus.mem_valid    = mem_valid_int;
    assign bus.mem_addr     = mem_valid_int ? ADDR_W'(head.addr) : '0;
    assign bus.mem_wdata    = mem_valid_int ? head.wdata : '0;
    assign bus.mem_be       = mem_valid_int ? head.be : '0;
    assign bus.mem_lossy    = mem_valid_int && head.lossy;
    assign bus.misalign_err = err_reg;
    assign count            = count_reg;

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Store-side counterpart of the immediate/load sign-extension path: takes 32-bit store data from the EX/MEM boundary and narrows it to byte, halfword or word.
- Places the narrowed value on the correct byte lanes and generates byte enables.
- Flags values that would not sign-extend back to the original operand.
- Buffers accepted stores in a small FIFO and drains them to data memory over a valid/ready handshake.

Parameters:
DEPTH, 2, number of store-buffer entries (power of two, at least 2)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
flush  in  1  synchronous buffer clear (pipeline squash)
in_valid  in  1  store request present
in_ready  out  1  buffer can accept; equals !full
in_addr  in  ADDR_W  byte address
in_data  in  32  register rt value
in_size  in  2  00 byte, 01 half, 10 word, 11 reserved
mem_valid  out  1  head entry valid
mem_ready  in  1  memory accepts head entry
mem_addr  out  ADDR_W  word-aligned address, {in_addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-aligned data
mem_be  out  4  byte enables, bit i = byte lane i
mem_lossy  out  1  head entry narrowing lost information
misalign_err  out  1  one-cycle pulse, request rejected
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - count=0; mem_valid=0; misalign_err=0.
  - mem_addr, mem_wdata, mem_be and mem_lossy read 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-drain discards all entries, including the head.
- Accept: in_valid && in_ready at an edge.
- Legal request:
  - Narrowing and lane alignment are computed combinationally.
  - The entry is written into the FIFO tail at that edge.
  - If the buffer was empty, mem_valid=1 in the next cycle (latency 1). No combinational in-to-mem path.
- Lane mapping is little-endian; lane = in_addr[1:0].
  - Byte: wdata = {4{in_data[7:0]}}, be = 4'b0001 << lane.
  - Half: wdata = {2{in_data[15:0]}}, be = 4'b0011 << lane.
  - Word: wdata = in_data, be = 4'b1111.
- Lossy flag, stored per entry:
  - Byte: in_data[31:7] not all-equal.
  - Half: in_data[31:15] not all-equal.
  - Word: never lossy.
  - This is the inverse check of sign extension. It is informational only; the store still proceeds.
- Misaligned or illegal request:
  - Condition: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Handshake completes but nothing is enqueued.
  - misalign_err=1 for exactly the cycle after the accept edge.
- Drain: mem_valid && mem_ready at an edge pops the head.
  - Head outputs hold stable while mem_valid && !mem_ready.
- Simultaneous push and pop:
  - Not full: both occur; count unchanged.
  - Full: in_ready=0, so no push even if a pop occurs that cycle (no same-cycle bypass).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full when count==DEPTH; empty when count==0.
- flush=1 at an edge:
  - Sets count=0 and resets pointers; any push that cycle is dropped.
  - mem_valid=0 next cycle.
  - misalign_err is suppressed for that cycle's accept.
- Priority: rst_n > flush > push/pop.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - entry struct {addr, wdata, be, lossy}.
  - function is_misaligned(size, addr_lo).
- One sub-module, store_lane_align: purely combinational narrowing, byte-enable and lossy-flag logic.
- The top module holds the FIFO storage, pointers, count and error pulse.

Test Plan:
- Byte store, addr 0x1003, data 0xFFFFFF80 -> next cycle mem_addr=0x1000, mem_be=1000, mem_wdata=0x80808080, mem_lossy=0.
- Half store, addr 0x2002, data 0x00012345, mem_ready=1 -> mem_be=1100, mem_wdata=0x23452345, mem_lossy=1; popped on the same cycle it appears.
- Word store to 0x3001, then half store to 0x3001 -> no enqueue, misalign_err pulses for one cycle after each, count stays 0; size 11 also pulses.
- mem_ready=0 with 3 legal stores offered (DEPTH=2) -> in_ready=0 after the 2nd accept, count=2.
  - Raise mem_ready: entries drain in order, third store accepted once count<2, pointers wrap correctly.
- Full buffer with simultaneous pop and in_valid -> pop occurs, push deferred one cycle, count goes 2->1->2.
- flush asserted with 2 entries pending plus a push in the same cycle -> count=0, mem_valid=0 next cycle.
  - Also: rst_n=0 during a stalled drain -> all outputs at reset values next cycle.
